// File: rtl/cc_pkg.sv
// cc_pkg: shared types and widths for the CC sequencing controller
package cc_pkg;
   localparam int NUM_OPS = 4;
   localparam int OP_W    = 4;
   localparam int OPT_W   = 3;
   localparam int RES_W   = 9;
   localparam int BEAT_W  = $clog2(NUM_OPS);
   localparam int CNT_W   = 3;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;
endpackage

// File: rtl/cc_settle_timer.sv
// cc_settle_timer: loadable down-counter, done while the count sits at 1
module cc_settle_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign done = cnt == W'(1);
endmodule

// File: rtl/cc_seq_ctrl.sv
// cc_seq_ctrl: assembles four serial operand nibbles for the CC datapath,
// holds them for SETTLE cycles and returns the captured result as a strobe.
module cc_seq_ctrl
   import cc_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [OP_W-1:0]  in_data,
   input  logic [OPT_W-1:0] in_opt,
   input  logic [RES_W-1:0] cc_out,
   output logic [OP_W-1:0]  cc_n0,
   output logic [OP_W-1:0]  cc_n1,
   output logic [OP_W-1:0]  cc_n2,
   output logic [OP_W-1:0]  cc_n3,
   output logic [OPT_W-1:0] cc_opt,
   output logic             busy,
   output logic             out_valid,
   output logic [RES_W-1:0] out_data
);
   if (SETTLE < 1 || SETTLE > 7) begin : g_bad_settle
      $error("cc_seq_ctrl: SETTLE must be in 1..7");
   end
   state_t            state, state_nxt;
   logic [BEAT_W-1:0] beat;
   logic [OP_W-1:0]   n_q [NUM_OPS];
   logic [OPT_W-1:0]  opt_q;
   logic              accept0, accept_n, last_beat, capture, settle_done;
   always_comb begin
      accept0   = in_valid && (state == IDLE || state == OUT);
      accept_n  = in_valid && state == LOAD;
      last_beat = accept_n && beat == BEAT_W'(NUM_OPS - 1);
      capture   = state == WAIT && settle_done;
      state_nxt = state;
      case (state)
         IDLE: state_nxt = in_valid ? LOAD : IDLE;
         LOAD: state_nxt = !in_valid ? IDLE : last_beat ? WAIT : LOAD;
         WAIT: state_nxt = settle_done ? OUT : WAIT;
         OUT:  state_nxt = in_valid ? LOAD : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // Beat index wraps to 0 after the last operand, ready for the next transaction.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         beat      <= '0;
         n_q       <= '{default: '0};
         opt_q     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= capture;
         out_data  <= capture ? cc_out : '0;
         if (accept0) begin
            n_q[0] <= in_data;
            opt_q  <= in_opt;
            beat   <= BEAT_W'(1);
         end else if (accept_n) begin
            n_q[beat] <= in_data;
            beat      <= beat + BEAT_W'(1);
         end else if (state == LOAD) begin
            beat <= '0;
         end
      end
   cc_settle_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (last_beat),
      .load_val (CNT_W'(SETTLE)),
      .done     (settle_done)
   );
   assign busy   = state == LOAD || state == WAIT;
   assign cc_n0  = n_q[0];
   assign cc_n1  = n_q[1];
   assign cc_n2  = n_q[2];
   assign cc_n3  = n_q[3];
   assign cc_opt = opt_q;
endmodule

// File: tb/tb_cc_seq_ctrl.sv
// tb_cc_seq_ctrl: directed bench driving SETTLE=1 and SETTLE=3 controllers
// with a shared operand stream and per-instance result stubs.
module tb_cc_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst_n, in_valid;
   logic [3:0] in_data;
   logic [2:0] in_opt;
   logic [8:0] cc1, cc3;
   logic [3:0] s1_n0, s1_n1, s1_n2, s1_n3, s3_n0, s3_n1, s3_n2, s3_n3;
   logic [2:0] s1_opt, s3_opt;
   logic       s1_busy, s1_ov, s3_busy, s3_ov;
   logic [8:0] s1_od, s3_od;
   int         tests = 0;
   int         fails = 0;
   always #5 clk = ~clk;
   cc_seq_ctrl #(.SETTLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_opt(in_opt),
      .cc_out(cc1), .cc_n0(s1_n0), .cc_n1(s1_n1), .cc_n2(s1_n2), .cc_n3(s1_n3),
      .cc_opt(s1_opt), .busy(s1_busy), .out_valid(s1_ov), .out_data(s1_od)
   );
   cc_seq_ctrl #(.SETTLE(3)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_opt(in_opt),
      .cc_out(cc3), .cc_n0(s3_n0), .cc_n1(s3_n1), .cc_n2(s3_n2), .cc_n3(s3_n3),
      .cc_opt(s3_opt), .busy(s3_busy), .out_valid(s3_ov), .out_data(s3_od)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic out1(input string tag, input logic b, input logic v, input logic [8:0] d);
      chk(tag, {s1_busy, s1_ov, s1_od}, {b, v, d});
   endtask
   task automatic out3(input string tag, input logic b, input logic v, input logic [8:0] d);
      chk(tag, {s3_busy, s3_ov, s3_od}, {b, v, d});
   endtask
   task automatic ops1(input string tag, input logic [3:0] a, b, c, d, input logic [2:0] o);
      chk(tag, {s1_n0, s1_n1, s1_n2, s1_n3, s1_opt}, {a, b, c, d, o});
   endtask
   task automatic ops3(input string tag, input logic [3:0] a, b, c, d, input logic [2:0] o);
      chk(tag, {s3_n0, s3_n1, s3_n2, s3_n3, s3_opt}, {a, b, c, d, o});
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_opt = '0; cc1 = '0; cc3 = '0;
      repeat (3) tick;
      out1("rst_out1", 0, 0, 0); out3("rst_out3", 0, 0, 0);
      ops1("rst_ops1", 0, 0, 0, 0, 0); ops3("rst_ops3", 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick; out1("idle1", 0, 0, 0); out3("idle3", 0, 0, 0);
      end
      // nominal transaction, also first SETTLE=3 transaction
      tick; in_valid = 1; in_data = 4'h3; in_opt = 3'b101;
      tick; out1("load1", 1, 0, 0); out3("load3", 1, 0, 0); in_data = 4'hA; in_opt = 3'b000;
      tick; in_data = 4'h1;
      tick; in_data = 4'hF;
      tick; in_valid = 0;
      ops1("nom_ops1", 4'h3, 4'hA, 4'h1, 4'hF, 3'd5); ops3("nom_ops3", 4'h3, 4'hA, 4'h1, 4'hF, 3'd5);
      out1("wait1", 1, 0, 0); out3("wait3", 1, 0, 0);
      cc1 = 9'h1A5; cc3 = 9'h055;
      tick; out1("nom_out1", 0, 1, 9'h1A5); out3("wait3b", 1, 0, 0); cc1 = 9'h000; cc3 = 9'h0AA;
      tick; out1("nom_clr1", 0, 0, 0); out3("wait3c", 1, 0, 0); cc3 = 9'h133;
      tick; out3("s3_out", 0, 1, 9'h133); out1("idle1b", 0, 0, 0);
      cc3 = 9'h000; in_valid = 1; in_data = 4'h4; in_opt = 3'd2;
      tick; out3("b2b_load3", 1, 0, 0); in_data = 4'h5;
      tick; in_data = 4'h6;
      tick; in_data = 4'h7;
      tick; in_valid = 0;
      ops3("b2b_ops3", 4'h4, 4'h5, 4'h6, 4'h7, 3'd2); ops1("b2b_ops1", 4'h4, 4'h5, 4'h6, 4'h7, 3'd2);
      cc1 = 9'h0AB; cc3 = 9'h1FF;
      tick; out1("b2b_out1", 0, 1, 9'h0AB); out3("b2b_wait3", 1, 0, 0);
      tick; out1("b2b_clr1", 0, 0, 0); out3("b2b_wait3b", 1, 0, 0); cc3 = 9'h1F0;
      tick; out3("b2b_out3", 0, 1, 9'h1F0);
      tick; out3("b2b_clr3", 0, 0, 0);
      // aborted load after two beats
      tick; in_valid = 1; in_data = 4'h9; in_opt = 3'd3;
      tick; in_data = 4'h8;
      tick; in_valid = 0; out1("abort_ld1", 1, 0, 0); out3("abort_ld3", 1, 0, 0);
      tick; out1("abort_idle1", 0, 0, 0); out3("abort_idle3", 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         tick; out1("abort_quiet1", 0, 0, 0); out3("abort_quiet3", 0, 0, 0);
      end
      // full transaction, in_valid held high into the settle window
      tick; in_valid = 1; in_data = 4'hC; in_opt = 3'd7;
      tick; in_data = 4'hD; in_opt = 3'd0;
      tick; in_data = 4'hE;
      tick; in_data = 4'hB;
      tick; in_data = 4'h1;
      ops1("hold_ops1", 4'hC, 4'hD, 4'hE, 4'hB, 3'd7); ops3("hold_ops3", 4'hC, 4'hD, 4'hE, 4'hB, 3'd7);
      cc1 = 9'h1C3; cc3 = 9'h000;
      tick; in_data = 4'h2;
      out1("hold_out1", 0, 1, 9'h1C3); out3("hold_wait3", 1, 0, 0);
      ops3("hold_ops3a", 4'hC, 4'hD, 4'hE, 4'hB, 3'd7);
      tick; in_data = 4'h3;
      ops3("hold_ops3b", 4'hC, 4'hD, 4'hE, 4'hB, 3'd7);
      ops1("out_beat0_ops1", 4'h2, 4'hD, 4'hE, 4'hB, 3'd0); out1("out_beat0_busy1", 1, 0, 0);
      cc3 = 9'h07E;
      tick; in_valid = 0;
      out3("hold_out3", 0, 1, 9'h07E); out1("out_beat0_ld1", 1, 0, 0);
      tick; out1("hold_idle1", 0, 0, 0); out3("hold_idle3", 0, 0, 0);
      // asynchronous reset while settling
      tick; in_valid = 1; in_data = 4'h1; in_opt = 3'd1;
      tick; in_data = 4'h2;
      tick; in_data = 4'h3;
      tick; in_data = 4'h4;
      tick; in_valid = 0; cc1 = 9'h111; cc3 = 9'h122;
      tick; out1("pre_rst_out1", 0, 1, 9'h111); out3("pre_rst_wait3", 1, 0, 0);
      #2 rst_n = 0;
      #1;
      out1("async_rst1", 0, 0, 0); out3("async_rst3", 0, 0, 0);
      ops1("async_ops1", 0, 0, 0, 0, 0); ops3("async_ops3", 0, 0, 0, 0, 0);
      tick; tick; rst_n = 1;
      for (int i = 0; i < 10; i++) begin
         tick; out1("post_rst1", 0, 0, 0); out3("post_rst3", 0, 0, 0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/cc_seq_ctrl.md
# cc_seq_ctrl

Sequencing controller for the four-operand CC compute datapath. It accepts operands serially over a valid-qualified 4-bit stream, assembles them with the opcode, and drives the CC operand and opt ports. It holds them stable for a programmable settle window, then captures the 9-bit result and emits it as a one-cycle registered output. It sits between the testbench/pattern interface and the purely combinational CC block, which is instantiated alongside it at the same level.

## Interface
- SETTLE, default 1, CC settle cycles between operand presentation and result capture; legal range 1..7
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  operand beat qualifier
- in_data  input  4  operand nibble; beat k feeds operand n_k
- in_opt  input  3  opcode; sampled only on beat 0
- cc_out  input  9  result from the CC datapath (combinational)
- cc_n0, cc_n1, cc_n2, cc_n3  output  4 each  operands to CC
- cc_opt  output  3  opcode to CC
- busy  output  1  high while a transaction is being loaded or is settling
- out_valid  output  1  result strobe, one cycle
- out_data  output  9  captured result; 0 whenever out_valid is low

## Operation
- States: IDLE, LOAD, WAIT, OUT.
- IDLE:
  - If in_valid is high, register in_data into n0 and in_opt into the opcode register, set beat=1, and go to LOAD.
- LOAD:
  - If in_valid is high, register in_data into n[beat] and increment beat.
  - On the beat-3 write, load settle_cnt=SETTLE and go to WAIT.
  - If in_valid is low before beat 3, the partial transaction is discarded: return to IDLE, produce no output, and clear beat. Operand registers keep their stale values; they are don't-care.
- WAIT:
  - in_valid is ignored.
  - settle_cnt decrements each cycle.
  - When settle_cnt==1, register cc_out into out_data, assert out_valid on the next cycle, and go to OUT.
- OUT:
  - out_valid=1 for exactly this cycle.
  - If in_valid is high in OUT, treat it as beat 0 of a new transaction and go to LOAD. Otherwise go to IDLE.
  - out_data returns to 0 on the following cycle.
- cc_n0..3 and cc_opt are driven directly from the operand/opcode registers. They are stable from the cycle after beat 3 through the capture edge.
- busy = (state==LOAD) || (state==WAIT). It is also high in IDLE/OUT on a cycle where in_valid is accepted? No: busy is a registered function of state only.
- No arithmetic in this block. All widths pass through unchanged. out_data is never truncated (9 bits end to end).

## Timing
- Reset (rst_n low, asynchronous, at any time including mid-LOAD or mid-WAIT):
  - state=IDLE, beat=0, settle_cnt=0.
  - All operand/opcode registers are 0, so cc_n*=0 and cc_opt=0.
  - busy=0, out_valid=0, out_data=0.
  - An in-flight transaction is lost and produces no output.
- Latency: with the final beat at cycle t, out_valid is high in cycle t+1+SETTLE. out_data equals cc_out as sampled at the end of cycle t+SETTLE.
- Throughput: a new beat 0 may arrive in the OUT cycle. The minimum transaction period is 4+SETTLE cycles.
- in_valid during WAIT: ignored and not buffered. Upstream must watch busy.
- SETTLE outside 1..7: illegal, elaboration-time error.

## Structure
- Shared package cc_pkg:
  - state enum {IDLE, LOAD, WAIT, OUT}
  - localparams NUM_OPS=4, OP_W=4, OPT_W=3, RES_W=9
  - beat counter width $clog2(NUM_OPS)
- One natural sub-module: cc_settle_timer, a loadable down-counter with SETTLE-width load and a done flag at count==1. It is reusable for other combinational-datapath wrappers.
- The CC datapath itself is not instantiated inside this block. It is wired beside it in the parent.

## Test plan
- Reset then idle: rst_n=0 for 3 cycles, then 1 with in_valid=0 for 20 cycles -> all outputs 0 throughout, busy=0.
- Nominal, SETTLE=1: beats 4'h3, 4'hA, 4'h1, 4'hF with in_opt=3'b101 on beat 0 (cycles 0-3); cc_out stub returns 9'h1A5 -> cc_n0..3=3,A,1,F and cc_opt=5 from cycle 4; out_valid=1 with out_data=9'h1A5 only in cycle 5.
- SETTLE=3, back-to-back: second transaction beat 0 issued in the first OUT cycle -> first out_valid in cycle 7, second out_valid in cycle 14, no gap errors.
- Aborted load: in_valid high for 2 beats then low -> no out_valid, busy falls next cycle; a following full transaction completes normally.
- in_valid held high through WAIT: extra nibbles do not alter cc_n*; out_data matches the first four beats.
- Reset mid-WAIT: assert rst_n=0 during settle countdown -> outputs 0 immediately (asynchronous), no out_valid after release.
